// File: rtl/mux_feed_seq_if.sv
// Handshake and mux-drive bundle for mux_feed_seq: upstream word input plus
// the registered data/select pair that feeds the downstream 4:1 mux.
interface mux_feed_seq_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       hold;
  logic [3:0] mux_in;
  logic [1:0] select;
  logic       out_valid;
  logic       out_last;
  logic [7:0] frame_cnt;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, mux_in, select, out_valid, out_last, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, mux_in, select, out_valid, out_last, frame_cnt
  );
endinterface

// File: rtl/mux_feed_seq.sv
// Serialises a 4-bit word into four mux beats by stepping the select of a
// downstream 4:1 mux; supports stall (hold) and back-to-back words.
//
// state | meaning
// IDLE  | no word in flight, ready for a new word
// SHIFT | presenting beats of the current word
module mux_feed_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  mux_feed_seq_if.slave  bus
);

  localparam logic [1:0] START_SEL = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0] END_SEL   = MSB_FIRST ? 2'd0 : 2'd3;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [3:0] mux_q, mux_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ready;
  logic       last;

  assign last = valid_q && (sel_q == END_SEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mux_q   <= 4'd0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      mux_q   <= mux_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mux_d   = mux_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          mux_d   = bus.in_data;
          sel_d   = START_SEL;
          valid_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.hold) begin
          if (last) begin
            ready = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (bus.in_valid) begin
              // next word loads straight over the last beat: no bubble
              mux_d = bus.in_data;
              sel_d = START_SEL;
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            sel_d = MSB_FIRST ? (sel_q - 2'd1) : (sel_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is masked so the port reads 0 for the whole time reset is held
  assign bus.in_ready  = ready & ~rst;
  assign bus.mux_in    = mux_q;
  assign bus.select    = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_mux_feed_seq.sv
// Bench for mux_feed_seq: LSB-first and MSB-first instances driven in
// lockstep, beat-level scoreboard plus table-driven words and corner sequences.
module tb_mux_feed_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_feed_seq_if b0 ();
  mux_feed_seq_if b1 ();

  mux_feed_seq #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(b0));
  mux_feed_seq #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(b1));

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected beat: select and mux output for each instance, plus last flag
  typedef struct packed {
    logic [1:0] s0;
    logic       v0;
    logic [1:0] s1;
    logic       v1;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   m_pend = 0;
  logic [7:0] m_frames = 8'd0;
  logic m_rdy, m_cons, m_acc;

  assign m_rdy  = (m_pend == 0) || (m_pend == 1 && !b0.hold);
  assign m_cons = (m_pend != 0) && !b0.hold;
  assign m_acc  = b0.in_valid && m_rdy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend   <= 0;
      m_frames <= 8'd0;
      q.delete();
    end else begin
      if (m_cons) void'(q.pop_front());
      if (m_cons && m_pend == 1) m_frames <= m_frames + 8'd1;
      if (m_acc) begin
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          e.s0   = 2'(k);
          e.v0   = b0.in_data[k];
          e.s1   = 2'(3 - k);
          e.v1   = b0.in_data[3 - k];
          e.last = (k == 3);
          q.push_back(e);
        end
      end
      m_pend <= m_pend - (m_cons ? 1 : 0) + (m_acc ? 4 : 0);
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready0", 32'(b0.in_ready), 32'(m_rdy));
      chk("in_ready1", 32'(b1.in_ready), 32'(m_rdy));
      chk("out_valid0", 32'(b0.out_valid), 32'(m_pend != 0));
      chk("out_valid1", 32'(b1.out_valid), 32'(m_pend != 0));
      chk("frame_cnt0", 32'(b0.frame_cnt), 32'(m_frames));
      chk("frame_cnt1", 32'(b1.frame_cnt), 32'(m_frames));
      if (m_pend != 0 && q.size() != 0) begin
        mon_e = q[0];
        chk("select0", 32'(b0.select), 32'(mon_e.s0));
        chk("mux_bit0", 32'(b0.mux_in[b0.select]), 32'(mon_e.v0));
        chk("out_last0", 32'(b0.out_last), 32'(mon_e.last));
        chk("select1", 32'(b1.select), 32'(mon_e.s1));
        chk("mux_bit1", 32'(b1.mux_in[b1.select]), 32'(mon_e.v1));
        chk("out_last1", 32'(b1.out_last), 32'(mon_e.last));
      end else begin
        chk("idle_last0", 32'(b0.out_last), 32'd0);
        chk("idle_last1", 32'(b1.out_last), 32'd0);
      end
    end
  end

  // counts valid cycles on the LSB-first instance while enabled
  logic cnt_en = 1'b0;
  int   vcnt = 0;
  always @(negedge clk) begin
    if (!cnt_en) vcnt <= 0;
    else if (b0.out_valid) vcnt <= vcnt + 1;
  end

  task automatic drive(logic v, logic [3:0] d, logic h);
    b0.in_valid = v; b0.in_data = d; b0.hold = h;
    b1.in_valid = v; b1.in_data = d; b1.hold = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_mux0"}, 32'(b0.mux_in), 32'd0);
    chk({tag, "_sel0"}, 32'(b0.select), 32'd0);
    chk({tag, "_valid0"}, 32'(b0.out_valid), 32'd0);
    chk({tag, "_ready0"}, 32'(b0.in_ready), 32'd0);
    chk({tag, "_last0"}, 32'(b0.out_last), 32'd0);
    chk({tag, "_cnt0"}, 32'(b0.frame_cnt), 32'd0);
    chk({tag, "_mux1"}, 32'(b1.mux_in), 32'd0);
    chk({tag, "_sel1"}, 32'(b1.select), 32'd0);
    chk({tag, "_valid1"}, 32'(b1.out_valid), 32'd0);
    chk({tag, "_ready1"}, 32'(b1.in_ready), 32'd0);
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst");
    #2 rst = 1'b0;
    tick();
  endtask

  // present one word for a single cycle, then walk its beats with an optional stall
  task automatic send_word(logic [3:0] d, int hb, int hl);
    int t = 0;
    while (m_pend != 0 && t < 50) begin
      drive(1'b0, 4'($urandom), 1'b0);
      tick();
      t++;
    end
    chk("idle_wait", 32'(t < 50), 32'd1);
    drive(1'b1, d, 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b == hb && hl > 0) begin
        repeat (hl) begin
          drive(1'b1, 4'($urandom), 1'b1);
          tick();
        end
      end
      drive(1'b0, 4'($urandom), 1'b0);
      tick();
    end
  endtask

  typedef struct {
    logic [3:0] data;
    int         hold_beat;
    int         hold_len;
    int         idle_after;
    logic [7:0] exp_frames;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b1010, 0, 0, 2, 8'd1};
    vecs[1] = '{4'b1100, 1, 3, 0, 8'd2};
    vecs[2] = '{4'b0110, 0, 1, 1, 8'd3};
    vecs[3] = '{4'b1111, 3, 2, 0, 8'd4};
    vecs[4] = '{4'b0001, 2, 5, 3, 8'd5};
    vecs[5] = '{4'b1000, 3, 0, 1, 8'd6};

    drive(1'b0, 4'd0, 1'b0);
    #2 check_reset_outputs("por");
    tick();
    rst = 1'b0;
    tick();

    // table-driven words, idle cycles with hold high and junk data between
    foreach (vecs[i]) begin
      send_word(vecs[i].data, vecs[i].hold_beat, vecs[i].hold_len);
      chk("vec_frames0", 32'(b0.frame_cnt), 32'(vecs[i].exp_frames));
      chk("vec_frames1", 32'(b1.frame_cnt), 32'(vecs[i].exp_frames));
      repeat (vecs[i].idle_after) begin
        drive(1'b0, 4'($urandom), 1'b1);
        tick();
      end
    end

    // stall of 3 cycles at select=1: 7 valid cycles for 4 beats
    do_reset();
    cnt_en = 1'b1;
    send_word(4'b1010, 1, 3);
    chk("hold_valid_cycles", 32'(vcnt), 32'd7);
    chk("hold_frames", 32'(b0.frame_cnt), 32'd1);
    cnt_en = 1'b0;
    tick();

    // back-to-back words with in_valid held high
    do_reset();
    cnt_en = 1'b1;
    drive(1'b1, 4'hA, 1'b0);
    tick();
    drive(1'b1, 4'h5, 1'b0);
    repeat (4) tick();
    drive(1'b0, 4'h0, 1'b0);
    repeat (4) tick();
    chk("b2b_valid_cycles", 32'(vcnt), 32'd8);
    chk("b2b_frames", 32'(b0.frame_cnt), 32'd2);
    cnt_en = 1'b0;
    tick();
    chk("b2b_idle_valid", 32'(b0.out_valid), 32'd0);

    // asynchronous reset at beat 2 aborts the word
    do_reset();
    drive(1'b1, 4'b0111, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0);
    repeat (2) tick();
    chk("pre_abort_sel", 32'(b0.select), 32'd2);
    #3 rst = 1'b1;
    #1 check_reset_outputs("abort");
    #2 rst = 1'b0;
    tick();
    send_word(4'b1001, 4, 0);
    chk("post_abort_frames", 32'(b0.frame_cnt), 32'd1);

    // 256 back-to-back words wrap the frame counter
    do_reset();
    drive(1'b1, 4'h3, 1'b0);
    tick();
    for (int w = 1; w < 256; w++) begin
      drive(1'b1, 4'(w * 7), 1'b0);
      repeat (4) tick();
    end
    drive(1'b0, 4'h0, 1'b0);
    repeat (3) tick();
    chk("wrap_pre_last", 32'(b0.frame_cnt), 32'd255);
    tick();
    chk("wrap_frames0", 32'(b0.frame_cnt), 32'd0);
    chk("wrap_frames1", 32'(b1.frame_cnt), 32'd0);
    chk("wrap_idle", 32'(b0.out_valid), 32'd0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_feed_seq.md
MUX_FEED_SEQ -- requirements
Module: mux_feed_seq

Interface
REQ-001 Parameter MSB_FIRST, default 0; 0 = beats presented select 0,1,2,3; 1 = beats presented select 3,2,1,0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream has a 4-bit word on in_data.
REQ-005 in_data  input  4  parallel word to be serialised through the downstream 4:1 mux.
REQ-006 in_ready  output  1  block accepts in_data this cycle when in_valid is also high.
REQ-007 hold  input  1  downstream stall; freezes the current beat.
REQ-008 mux_in  output  4  registered word driving the data inputs of the downstream 4:1 mux.
REQ-009 select  output  2  registered select driving the downstream 4:1 mux.
REQ-010 out_valid  output  1  mux_in/select form a valid beat this cycle.
REQ-011 out_last  output  1  current beat is the 4th beat of the word.
REQ-012 frame_cnt  output  8  count of completed words, wraps 255->0.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 Accept = in_valid & in_ready; in_ready SHALL be 1 in IDLE, 1 in SHIFT only on the last beat with hold=0, and 0 otherwise.
REQ-015 On accept in IDLE: mux_in<=in_data, select<=start index (0 if MSB_FIRST=0, else 3), out_valid<=1, state<=SHIFT; first beat visible the cycle after accept (latency 1).
REQ-016 In SHIFT with hold=0 and not last beat: select SHALL step +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1); mux_in unchanged.
REQ-017 In SHIFT with hold=1: select, mux_in, out_valid, out_last and state SHALL be unchanged; in_ready=0.
REQ-018 out_last SHALL be combinationally 1 when out_valid=1 and select equals end index (3 if MSB_FIRST=0, else 0).
REQ-019 On last beat with hold=0: frame_cnt SHALL increment by 1 mod 256.
REQ-020 On last beat with hold=0 and accept: new word loaded as in REQ-015, state stays SHIFT, no bubble (back-to-back words).
REQ-021 On last beat with hold=0 and no accept: out_valid<=0, state<=IDLE; mux_in and select retain last values.
REQ-022 Each accepted word SHALL produce exactly 4 beats with out_valid=1, each select value exactly once, regardless of hold pattern.
REQ-023 in_data SHALL be ignored when no accept occurs; in_valid while in_ready=0 has no effect.
REQ-024 In IDLE, hold SHALL have no effect.

Reset
REQ-025 While rst=1 (asynchronous, no clock needed): state=IDLE, mux_in=0, select=0, out_valid=0, frame_cnt=0, in_ready=0, out_last=0.
REQ-026 Reset asserted mid-word SHALL abort the word with no frame_cnt increment; first edge after rst deassert behaves as IDLE.

Verification
REQ-027 MSB_FIRST=0, single word in_data=4'b1010, hold=0 -> 4 cycles out_valid=1, select 0,1,2,3, out_last on 4th, mux output 0,1,0,1, frame_cnt=1, then out_valid=0.
REQ-028 MSB_FIRST=1, in_data=4'b1100 -> select 3,2,1,0, mux output 1,1,0,0, out_last with select=0.
REQ-029 hold=1 for 3 cycles while select=1 -> select stays 1, in_ready=0, then resumes 2,3; total valid beats 4, total 7 valid cycles.
REQ-030 in_valid held high with words 4'hA,4'h5 -> 8 consecutive valid beats, no gap, in_ready pulses only on beats 4 and 8 (plus IDLE), frame_cnt=2.
REQ-031 rst pulsed asynchronously (between edges) at beat 2 -> all outputs zero immediately, frame_cnt=0; next word after release starts at select=0.
REQ-032 256 words streamed back-to-back -> frame_cnt wraps to 0 after the 256th last beat.
